// File: rtl/cve2_obi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : cve2_obi_arbiter_pkg
// Brief  : Shared types for the instruction/data OBI arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package cve2_obi_arbiter_pkg;

  typedef enum logic {
    ObiSrcData  = 1'b0,
    ObiSrcInstr = 1'b1
  } obi_src_e;

  typedef enum logic [1:0] {
    ArbUnlocked    = 2'd0,
    ArbLockedData  = 2'd1,
    ArbLockedInstr = 2'd2
  } arb_state_e;

  function automatic obi_src_e obi_other_src(input obi_src_e src);
    return (src == ObiSrcData) ? ObiSrcInstr : ObiSrcData;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cve2_obi_id_fifo.sv
`default_nettype none
// ============================================================================
// Module : cve2_obi_id_fifo
// Brief  : In-order ID FIFO with occupancy count and simultaneous push/pop.
// Rev    : 1.0 - initial release
// ============================================================================
module cve2_obi_id_fifo import cve2_obi_arbiter_pkg::*; #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_push_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign o_full     = (r_count == c_CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rptr];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_inc(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/cve2_obi_arbiter.sv
`default_nettype none
// ============================================================================
// Module : cve2_obi_arbiter
// Brief  : 2:1 OBI arbiter sharing one memory port between fetch and data.
// Rev    : 1.0 - initial release
// ============================================================================
module cve2_obi_arbiter import cve2_obi_arbiter_pkg::*; #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RoundRobin     = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        protocol_err_o
);

  localparam int unsigned c_CNT_W = $clog2(MaxOutstanding + 1);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  obi_src_e           r_rr_ptr;
  obi_src_e           w_winner;
  obi_src_e           w_head;
  logic               r_proto_err;
  logic [0:0]         w_head_raw;
  logic [0:0]         w_push_id;
  logic [c_CNT_W-1:0] w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_win_req;
  logic               w_hs;
  logic               w_pop;

  always_comb begin
    w_winner    = ObiSrcData;
    w_state_nxt = ArbUnlocked;
    case (r_state)
      ArbLockedData:  w_winner = ObiSrcData;
      ArbLockedInstr: w_winner = ObiSrcInstr;
      default: begin
        if (RoundRobin && (r_rr_ptr == ObiSrcInstr)) begin
          w_winner = (instr_req_i || !data_req_i) ? ObiSrcInstr : ObiSrcData;
        end else begin
          w_winner = (data_req_i || !instr_req_i) ? ObiSrcData : ObiSrcInstr;
        end
      end
    endcase
    // A stalled request must keep its payload until granted, so pin the winner.
    if (mem_req_o && !mem_gnt_i) begin
      w_state_nxt = (w_winner == ObiSrcData) ? ArbLockedData : ArbLockedInstr;
    end
  end

  assign w_win_req = (w_winner == ObiSrcData) ? data_req_i : instr_req_i;
  assign mem_req_o = w_win_req && !w_full;
  assign w_hs      = mem_req_o && mem_gnt_i;

  assign data_gnt_o  = w_hs && (w_winner == ObiSrcData);
  assign instr_gnt_o = w_hs && (w_winner == ObiSrcInstr);

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'hF;
    mem_addr_o  = instr_addr_i;
    mem_wdata_o = '0;
    if (w_winner == ObiSrcData) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign w_push_id = w_winner;

  cve2_obi_id_fifo #(
    .DEPTH (MaxOutstanding),
    .WIDTH (1)
  ) u_id_fifo (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .i_push      (w_hs),
    .i_push_data (w_push_id),
    .i_pop       (w_pop),
    .o_pop_data  (w_head_raw),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign w_head = obi_src_e'(w_head_raw);
  assign w_pop  = mem_rvalid_i && !w_empty;

  assign data_rvalid_o  = w_pop && (w_head == ObiSrcData);
  assign instr_rvalid_o = w_pop && (w_head == ObiSrcInstr);
  assign data_rdata_o   = mem_rdata_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_err_o     = data_rvalid_o && mem_err_i;
  assign instr_err_o    = instr_rvalid_o && mem_err_i;
  assign protocol_err_o = r_proto_err;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ArbUnlocked;
      r_rr_ptr    <= ObiSrcData;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (RoundRobin && w_hs) r_rr_ptr <= obi_other_src(w_winner);
      if (mem_rvalid_i && (w_count == '0)) r_proto_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cve2_obi_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_cve2_obi_arbiter
// Brief  : Directed self-checking bench for fixed-priority and round-robin arbiters.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_cve2_obi_arbiter;

  typedef struct {
    logic        src;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_ni;
  logic instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_be;

  logic        a_instr_gnt, a_instr_rvalid, a_instr_err, a_data_gnt, a_data_rvalid, a_data_err;
  logic        a_mem_req, a_mem_we, a_proto_err;
  logic [31:0] a_instr_rdata, a_data_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        b_instr_gnt, b_instr_rvalid, b_instr_err, b_data_gnt, b_data_rvalid, b_data_err;
  logic        b_mem_req, b_mem_we, b_proto_err;
  logic [31:0] b_instr_rdata, b_data_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t cur;

  cve2_obi_arbiter #(.MaxOutstanding(2), .RoundRobin(1'b0)) dut_fixed (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req), .instr_gnt_o(a_instr_gnt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(a_instr_rvalid), .instr_rdata_o(a_instr_rdata), .instr_err_o(a_instr_err),
    .data_req_i(data_req), .data_gnt_o(a_data_gnt), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_rvalid_o(a_data_rvalid),
    .data_rdata_o(a_data_rdata), .data_err_o(a_data_err),
    .mem_req_o(a_mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .protocol_err_o(a_proto_err)
  );

  cve2_obi_arbiter #(.MaxOutstanding(2), .RoundRobin(1'b1)) dut_rr (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req), .instr_gnt_o(b_instr_gnt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(b_instr_rvalid), .instr_rdata_o(b_instr_rdata), .instr_err_o(b_instr_err),
    .data_req_i(data_req), .data_gnt_o(b_data_gnt), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_rvalid_o(b_data_rvalid),
    .data_rdata_o(b_data_rdata), .data_err_o(b_data_err),
    .mem_req_o(b_mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .protocol_err_o(b_proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic push_exp(input logic src, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.src = src; e.rdata = rdata; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic respond();
    chk1("sb_pending", sb_q.size() != 0, 1'b1);
    if (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = cur.rdata;
      mem_err    = cur.err;
    end
  endtask

  task automatic no_resp();
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic check_resp(input bit use_b);
    logic dv, iv, de, ie;
    logic [31:0] dr, ir;
    dv = use_b ? b_data_rvalid  : a_data_rvalid;
    iv = use_b ? b_instr_rvalid : a_instr_rvalid;
    de = use_b ? b_data_err     : a_data_err;
    ie = use_b ? b_instr_err    : a_instr_err;
    dr = use_b ? b_data_rdata   : a_data_rdata;
    ir = use_b ? b_instr_rdata  : a_instr_rdata;
    chk1(cur.src ? "instr_rvalid" : "data_rvalid", cur.src ? iv : dv, 1'b1);
    chk1("other_rvalid", cur.src ? dv : iv, 1'b0);
    chk32("resp_rdata", cur.src ? ir : dr, cur.rdata);
    chk1("resp_err", cur.src ? ie : de, cur.err);
  endtask

  initial begin
    rst_ni = 1'b0; instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
    instr_addr = '0; data_addr = '0; data_wdata = '0; mem_gnt = 1'b0;
    no_resp();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    settle();
    chk1("rst_proto_err", a_proto_err, 1'b0);
    chk1("rst_mem_req", a_mem_req, 1'b0);
    chk1("rst_data_gnt", a_data_gnt, 1'b0);
    chk1("rst_instr_gnt", a_instr_gnt, 1'b0);
    chk1("rst_rvalid", a_data_rvalid | a_instr_rvalid, 1'b0);
    chk1("rst_rr_proto_err", b_proto_err, 1'b0);
    tick();

    // Both request together: data wins under fixed priority.
    data_req = 1'b1; data_addr = 32'h100; data_be = 4'hF; data_we = 1'b0;
    instr_req = 1'b1; instr_addr = 32'h200; mem_gnt = 1'b1;
    settle();
    chk1("t1_mem_req", a_mem_req, 1'b1);
    chk32("t1_addr_data", a_mem_addr, 32'h100);
    chk1("t1_data_gnt", a_data_gnt, 1'b1);
    chk1("t1_instr_gnt0", a_instr_gnt, 1'b0);
    push_exp(1'b0, 32'hD0D0_0100, 1'b0);
    tick();
    data_req = 1'b0; respond();
    settle();
    chk32("t1_addr_instr", a_mem_addr, 32'h200);
    chk1("t1_instr_gnt", a_instr_gnt, 1'b1);
    chk1("t1_data_gnt0", a_data_gnt, 1'b0);
    check_resp(1'b0);
    push_exp(1'b1, 32'h1C1C_0200, 1'b0);
    tick();
    instr_req = 1'b0; respond();
    settle();
    chk1("t1_idle_req", a_mem_req, 1'b0);
    check_resp(1'b0);
    tick();

    // Stalled data request holds the downstream payload; then fill to the limit.
    no_resp(); mem_gnt = 1'b0;
    data_req = 1'b1; data_addr = 32'h300; data_we = 1'b1; data_be = 4'h3; data_wdata = 32'hAA55;
    settle();
    chk1("t2_req", a_mem_req, 1'b1);
    chk1("t2_gnt0_c1", a_data_gnt, 1'b0);
    tick();
    instr_req = 1'b1; instr_addr = 32'h204;
    settle();
    chk32("t2_addr_c2", a_mem_addr, 32'h300);
    chk1("t2_instr_gnt0_c2", a_instr_gnt, 1'b0);
    tick();
    settle();
    chk32("t2_addr_c3", a_mem_addr, 32'h300);
    chk32("t2_wdata_c3", a_mem_wdata, 32'hAA55);
    chk1("t2_instr_gnt0_c3", a_instr_gnt, 1'b0);
    tick();
    mem_gnt = 1'b1;
    settle();
    chk1("t2_data_gnt", a_data_gnt, 1'b1);
    chk1("t2_instr_gnt0_c4", a_instr_gnt, 1'b0);
    chk1("t2_we", a_mem_we, 1'b1);
    chk32("t2_be", {28'd0, a_mem_be}, 32'h3);
    push_exp(1'b0, 32'h3333_0300, 1'b0);
    tick();
    data_req = 1'b0;
    settle();
    chk1("t2_instr_gnt", a_instr_gnt, 1'b1);
    chk32("t2_addr_instr", a_mem_addr, 32'h204);
    push_exp(1'b1, 32'h4444_0204, 1'b0);
    tick();
    data_req = 1'b1; data_addr = 32'h304; data_we = 1'b0; data_be = 4'hF;
    settle();
    chk1("t3_full_req0", a_mem_req, 1'b0);
    chk1("t3_full_gnt0", a_data_gnt | a_instr_gnt, 1'b0);
    tick();
    respond();
    settle();
    chk1("t3_rvalid_same_cycle_req0", a_mem_req, 1'b0);
    check_resp(1'b0);
    tick();
    no_resp();
    settle();
    chk1("t3_req_reasserts", a_mem_req, 1'b1);
    chk1("t3_data_gnt", a_data_gnt, 1'b1);
    push_exp(1'b0, 32'h5555_0304, 1'b0);
    tick();
    data_req = 1'b0; instr_req = 1'b0; respond();
    settle(); check_resp(1'b0); tick();
    respond();
    settle(); check_resp(1'b0); tick();

    // Stalled instr request must not be overtaken by a later data request.
    no_resp(); mem_gnt = 1'b0;
    instr_req = 1'b1; instr_addr = 32'h500;
    settle();
    chk32("t4_addr_instr", a_mem_addr, 32'h500);
    chk1("t4_instr_gnt0", a_instr_gnt, 1'b0);
    tick();
    data_req = 1'b1; data_addr = 32'h308; data_we = 1'b1; data_be = 4'h1;
    settle();
    chk32("t4_lock_addr", a_mem_addr, 32'h500);
    chk1("t4_lock_we", a_mem_we, 1'b0);
    chk1("t4_data_gnt0", a_data_gnt, 1'b0);
    tick();
    mem_gnt = 1'b1;
    settle();
    chk1("t4_instr_gnt", a_instr_gnt, 1'b1);
    chk1("t4_data_gnt0_hs", a_data_gnt, 1'b0);
    chk32("t4_be", {28'd0, a_mem_be}, 32'hF);
    chk32("t4_wdata", a_mem_wdata, 32'h0);
    push_exp(1'b1, 32'hDEAD_BEEF, 1'b1);
    tick();
    instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; respond();
    settle(); check_resp(1'b0); tick();

    // Orphan response sets the sticky protocol error.
    no_resp(); mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    settle();
    chk1("t5_orphan_no_rvalid", a_data_rvalid | a_instr_rvalid, 1'b0);
    tick();
    no_resp();
    settle();
    chk1("t5_proto_set", a_proto_err, 1'b1);
    tick();
    settle();
    chk1("t5_proto_sticky", a_proto_err, 1'b1);
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    settle();
    chk1("t5_proto_cleared", a_proto_err, 1'b0);
    chk1("t5_rr_proto_clear", b_proto_err, 1'b0);
    tick();

    // Round-robin instance: alternating grants with both held.
    data_req = 1'b1; data_addr = 32'h600; data_we = 1'b0; data_be = 4'hF;
    instr_req = 1'b1; instr_addr = 32'h700; mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) respond();
      settle();
      chk1((i % 2 == 0) ? "rr_data_gnt" : "rr_instr_gnt",
           (i % 2 == 0) ? b_data_gnt : b_instr_gnt, 1'b1);
      chk1("rr_loser_gnt0", (i % 2 == 0) ? b_instr_gnt : b_data_gnt, 1'b0);
      chk32("rr_addr", b_mem_addr, (i % 2 == 0) ? 32'h600 : 32'h700);
      if (i > 0) check_resp(1'b1);
      push_exp(i % 2 == 1, 32'hC0DE_0000 | i, 1'b0);
      tick();
    end
    data_req = 1'b0; instr_req = 1'b0; mem_gnt = 1'b0; respond();
    settle(); check_resp(1'b1); tick();
    no_resp();
    chk32("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
